// File: rtl/operand_fetch_pkg.sv
// Shared word size, register-select encodings and sequencer states for operand_fetch.
package operand_fetch_pkg;

  localparam int WORD_SIZE = 19;

  localparam logic [1:0] REG_SEL_A    = 2'b00;
  localparam logic [1:0] REG_SEL_B    = 2'b01;
  localparam logic [1:0] REG_SEL_C    = 2'b10;
  localparam logic [1:0] REG_SEL_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WAIT,
    OUT
  } opfetch_state_t;

  function automatic logic sel_is_reg(input logic [1:0] sel);
    return sel != REG_SEL_NONE;
  endfunction

endpackage

// File: rtl/opfetch_arb.sv
// Register-file port mux: an active writeback overrides the sequencer's read select
// and raises stall while a read phase is in progress.
module opfetch_arb
  import operand_fetch_pkg::*;
#(
  parameter int W = WORD_SIZE
) (
  input  logic         wb_valid_i,
  input  logic [1:0]   wb_sel_i,
  input  logic [W-1:0] wb_data_i,
  input  logic         rd_phase_i,
  input  logic [1:0]   rd_sel_i,
  output logic         rf_load_o,
  output logic [1:0]   rf_sel_o,
  output logic [W-1:0] rf_wdata_o,
  output logic         stall_o
);

  logic wbActive;

  assign wbActive = wb_valid_i && sel_is_reg(wb_sel_i);
  assign stall_o  = wbActive && rd_phase_i;

  always_comb begin
    rf_load_o  = 1'b0;
    rf_sel_o   = rd_sel_i;
    rf_wdata_o = '0;
    if (wbActive) begin
      rf_load_o  = 1'b1;
      rf_sel_o   = wb_sel_i;
      rf_wdata_o = wb_data_i;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads two sources through the register file's registered port.
// Optional feature macro OPFETCH_DUP_SKIP_EN: identical sources are read only once.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int W     = WORD_SIZE,
  parameter int OPC_W = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPC_W-1:0] req_opc,
  input  logic [1:0]       req_src1,
  input  logic [1:0]       req_src2,
  input  logic [1:0]       req_dst,
  output logic             rf_load,
  output logic [1:0]       rf_sel,
  output logic [W-1:0]     rf_wdata,
  input  logic [W-1:0]     rf_rdata,
  input  logic             wb_valid,
  input  logic [1:0]       wb_sel,
  input  logic [W-1:0]     wb_data,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  output logic [1:0]       op_dst,
  output logic [OPC_W-1:0] op_opc
);

  opfetch_state_t   state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic [1:0]       src1_q, src1_d;
  logic [1:0]       src2_q, src2_d;
  logic [1:0]       dst_q, dst_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;

  logic             stall;
  logic             rdPhase;
  logic [1:0]       rdSel;
  logic             dupSkip;
  logic [W-1:0]     capA;
  logic [W-1:0]     capB;

`ifdef OPFETCH_DUP_SKIP_EN
  assign dupSkip = (src1_q == src2_q) && sel_is_reg(src1_q);
`else
  assign dupSkip = 1'b0;
`endif

  assign rdPhase = (state_q == RD1) || (state_q == RD2);
  assign rdSel   = (state_q == RD1) ? src1_q :
                   (state_q == RD2) ? src2_q : REG_SEL_NONE;

  // A NONE source never reaches the register file, so its operand is forced to zero
  assign capA = sel_is_reg(src1_q) ? rf_rdata : '0;
  assign capB = sel_is_reg(src2_q) ? rf_rdata : '0;

  opfetch_arb #(.W(W)) u_arb (
    .wb_valid_i (wb_valid),
    .wb_sel_i   (wb_sel),
    .wb_data_i  (wb_data),
    .rd_phase_i (rdPhase),
    .rd_sel_i   (rdSel),
    .rf_load_o  (rf_load),
    .rf_sel_o   (rf_sel),
    .rf_wdata_o (rf_wdata),
    .stall_o    (stall)
  );

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    dst_d   = dst_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          opc_d   = req_opc;
          src1_d  = req_src1;
          src2_d  = req_src2;
          dst_d   = req_dst;
          state_d = RD1;
        end
      end
      RD1: begin
        if (!stall) state_d = dupSkip ? WAIT : RD2;
      end
      // A stalled RD2 relies on the register file holding data_out across the write
      RD2: begin
        if (!stall) begin
          op_a_d  = capA;
          state_d = WAIT;
        end
      end
      WAIT: begin
        op_b_d = capB;
        if (dupSkip) op_a_d = capB;
        state_d = OUT;
      end
      OUT: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      opc_q   <= '0;
      src1_q  <= REG_SEL_NONE;
      src2_q  <= REG_SEL_NONE;
      dst_q   <= REG_SEL_NONE;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      dst_q   <= dst_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign op_valid  = (state_q == OUT);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_dst    = dst_q;
  assign op_opc    = opc_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch with a behavioural register file and
// an architectural register shadow; honours OPFETCH_DUP_SKIP_EN.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int W     = WORD_SIZE;
  localparam int OPC_W = 5;
`ifdef OPFETCH_DUP_SKIP_EN
  localparam int LAT_DUP = 3;
  localparam bit DUP_EN  = 1'b1;
`else
  localparam int LAT_DUP = 4;
  localparam bit DUP_EN  = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             req_valid;
  logic             req_ready;
  logic [OPC_W-1:0] req_opc;
  logic [1:0]       req_src1, req_src2, req_dst;
  logic             rf_load;
  logic [1:0]       rf_sel;
  logic [W-1:0]     rf_wdata;
  logic [W-1:0]     rf_rdata;
  logic             wb_valid;
  logic [1:0]       wb_sel;
  logic [W-1:0]     wb_data;
  logic             op_valid;
  logic             op_ready;
  logic [W-1:0]     op_a, op_b;
  logic [1:0]       op_dst;
  logic [OPC_W-1:0] op_opc;

  int testsRun = 0;
  int failures = 0;

  logic [W-1:0] rfRegs [4];
  logic [W-1:0] shadow [4];

  typedef struct {
    logic [1:0]       s1, s2, d;
    logic [OPC_W-1:0] opc;
    int               hold;
    int               wbCyc;
    logic [1:0]       wbS;
    logic [W-1:0]     wbD;
    logic [W-1:0]     expA, expB;
    int               expLat;
  } vec_t;

  vec_t vecs [8];

  operand_fetch #(.W(W), .OPC_W(OPC_W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opc   (req_opc),
    .req_src1  (req_src1),
    .req_src2  (req_src2),
    .req_dst   (req_dst),
    .rf_load   (rf_load),
    .rf_sel    (rf_sel),
    .rf_wdata  (rf_wdata),
    .rf_rdata  (rf_rdata),
    .wb_valid  (wb_valid),
    .wb_sel    (wb_sel),
    .wb_data   (wb_data),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_dst    (op_dst),
    .op_opc    (op_opc)
  );

  always #5 CLK = ~CLK;

  // Register file: registered read, data_out held during writes, junk on a NONE read
  always @(posedge CLK) begin
    if (rf_load) begin
      if (rf_sel != REG_SEL_NONE) rfRegs[rf_sel] <= rf_wdata;
    end else if (rf_sel != REG_SEL_NONE) begin
      rf_rdata <= rfRegs[rf_sel];
    end else begin
      rf_rdata <= W'($urandom);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    #2;
    if (wb_valid && wb_sel != REG_SEL_NONE)
      checkOutput("rf writeback drive", 32'({rf_load, rf_sel, rf_wdata}), 32'({1'b1, wb_sel, wb_data}));
    else
      checkOutput("rf idle drive", 32'({rf_load, rf_wdata}), 32'd0);
  end

  function automatic logic [W-1:0] readReg(input logic [1:0] s);
    return (s == REG_SEL_NONE) ? '0 : shadow[s];
  endfunction

  task automatic driveWb(input bit rnd, input bit fire, input logic [1:0] s, input logic [W-1:0] dat);
    if (rnd) begin
      wb_valid = ($urandom_range(0, 2) == 0);
      wb_sel   = 2'($urandom_range(0, 3));
      wb_data  = W'($urandom);
    end else begin
      wb_valid = fire;
      wb_sel   = fire ? s : REG_SEL_NONE;
      wb_data  = fire ? dat : '0;
    end
  endtask

  task automatic doWb(input logic [1:0] s, input logic [W-1:0] dat);
    driveWb(1'b0, 1'b1, s, dat);
    shadow[s] = dat;
    @(posedge CLK); @(negedge CLK);
    driveWb(1'b0, 1'b0, REG_SEL_NONE, '0);
  endtask

  // Runs one instruction from an idle negedge to the negedge after the op handshake.
  // Reads happen in the first and second writeback-free cycles after acceptance.
  task automatic applyStimulus(
    input  logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
    input  logic [OPC_W-1:0] opc, input int hold,
    input  bit rndWb, input int wbCyc, input logic [1:0] wbS, input logic [W-1:0] wbD,
    output logic [W-1:0] gotA, output logic [W-1:0] gotB, output logic [1:0] gotDst,
    output logic [OPC_W-1:0] gotOpc, output int gotLat,
    output logic [W-1:0] mdlA, output logic [W-1:0] mdlB, output int mdlLat);
    bit dup;
    bit active;
    int nReads, readsLeft, stalls;
    dup       = DUP_EN && (s1 == s2) && (s1 != REG_SEL_NONE);
    nReads    = dup ? 1 : 2;
    readsLeft = nReads;
    stalls    = 0;
    mdlA = '0; mdlB = '0; gotA = '0; gotB = '0;
    gotDst = REG_SEL_NONE; gotOpc = '0; gotLat = -1;
    checkOutput("req_ready before request", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_opc   = opc;
    req_src1  = s1;
    req_src2  = s2;
    req_dst   = d;
    driveWb(rndWb, wbCyc == 0, wbS, wbD);
    active = wb_valid && wb_sel != REG_SEL_NONE;
    if (active) shadow[wb_sel] = wb_data;
    @(posedge CLK); @(negedge CLK);
    req_valid = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (op_valid) begin
        gotLat = c;
        break;
      end
      driveWb(rndWb, wbCyc == c, wbS, wbD);
      active = wb_valid && wb_sel != REG_SEL_NONE;
      if (readsLeft > 0) begin
        if (active) stalls++;
        else begin
          if (readsLeft == nReads) begin
            mdlA = readReg(s1);
            if (dup) mdlB = mdlA;
          end else begin
            mdlB = readReg(s2);
          end
          readsLeft--;
        end
      end
      if (active) shadow[wb_sel] = wb_data;
      @(posedge CLK); @(negedge CLK);
    end
    driveWb(1'b0, 1'b0, REG_SEL_NONE, '0);
    mdlLat = (dup ? 3 : 4) + stalls;
    if (gotLat < 0) begin
      checkOutput("op_valid timeout", 32'd0, 32'd1);
      return;
    end
    gotA = op_a; gotB = op_b; gotDst = op_dst; gotOpc = op_opc;
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); @(negedge CLK);
      checkOutput("hold ctl", 32'({op_valid, req_ready, op_dst, op_opc}), 32'({1'b1, 1'b0, gotDst, gotOpc}));
      checkOutput("hold op_a", 32'(op_a), 32'(gotA));
      checkOutput("hold op_b", 32'(op_b), 32'(gotB));
    end
    op_ready = 1'b1;
    @(posedge CLK); @(negedge CLK);
    op_ready = 1'b0;
    checkOutput("after handshake", 32'({req_ready, op_valid}), 32'b10);
  endtask

  initial begin
    logic [W-1:0]     gA, gB, mA, mB;
    logic [1:0]       gD, rs1, rs2, rd;
    logic [OPC_W-1:0] gO, ropc;
    int               gL, mL;

    vecs[0] = '{REG_SEL_A, REG_SEL_B, REG_SEL_C, 5'd3, 0, -1, REG_SEL_NONE, 19'h0, 19'h12345, 19'h00ABC, 4};
    vecs[1] = '{REG_SEL_A, REG_SEL_B, REG_SEL_A, 5'd7, 0, 1, REG_SEL_B, 19'h7FFFF, 19'h12345, 19'h7FFFF, 5};
    vecs[2] = '{REG_SEL_C, REG_SEL_C, REG_SEL_B, 5'd31, 0, -1, REG_SEL_NONE, 19'h0, 19'h00001, 19'h00001, LAT_DUP};
    vecs[3] = '{REG_SEL_A, REG_SEL_NONE, REG_SEL_NONE, 5'd9, 0, -1, REG_SEL_NONE, 19'h0, 19'h12345, 19'h0, 4};
    vecs[4] = '{REG_SEL_A, REG_SEL_B, REG_SEL_C, 5'd12, 3, 3, REG_SEL_A, 19'h55555, 19'h12345, 19'h7FFFF, 4};
    vecs[5] = '{REG_SEL_A, REG_SEL_B, REG_SEL_B, 5'd1, 0, 2, REG_SEL_B, 19'h00042, 19'h55555, 19'h00042, 5};
    vecs[6] = '{REG_SEL_NONE, REG_SEL_NONE, REG_SEL_A, 5'd0, 1, -1, REG_SEL_NONE, 19'h0, 19'h0, 19'h0, 4};
    vecs[7] = '{REG_SEL_C, REG_SEL_A, REG_SEL_C, 5'd21, 0, 0, REG_SEL_C, 19'h00003, 19'h00003, 19'h55555, 4};

    RST_N = 1'b0;
    req_valid = 1'b0; req_opc = '0;
    req_src1 = REG_SEL_NONE; req_src2 = REG_SEL_NONE; req_dst = REG_SEL_NONE;
    wb_valid = 1'b0; wb_sel = REG_SEL_NONE; wb_data = '0;
    op_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("reset ctl", 32'({op_valid, req_ready, op_dst, op_opc}), 32'({1'b0, 1'b1, REG_SEL_NONE, 5'd0}));
    checkOutput("reset op_a/op_b", 32'({op_a, op_b} == '0), 32'd1);
    checkOutput("reset rf drive", 32'({rf_load, rf_sel, rf_wdata}), 32'({1'b0, REG_SEL_NONE, 19'h0}));
    RST_N = 1'b1;
    @(negedge CLK);

    doWb(REG_SEL_A, 19'h12345);
    doWb(REG_SEL_B, 19'h00ABC);
    doWb(REG_SEL_C, 19'h00001);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].opc, vecs[i].hold,
                    1'b0, vecs[i].wbCyc, vecs[i].wbS, vecs[i].wbD,
                    gA, gB, gD, gO, gL, mA, mB, mL);
      checkOutput($sformatf("vec%0d op_a", i), 32'(gA), 32'(vecs[i].expA));
      checkOutput($sformatf("vec%0d op_b", i), 32'(gB), 32'(vecs[i].expB));
      checkOutput($sformatf("vec%0d op_dst", i), 32'(gD), 32'(vecs[i].d));
      checkOutput($sformatf("vec%0d op_opc", i), 32'(gO), 32'(vecs[i].opc));
      checkOutput($sformatf("vec%0d latency", i), 32'(gL), 32'(vecs[i].expLat));
    end

    // Reset in RD2, with a writeback during reset still reaching the register file
    req_valid = 1'b1; req_src1 = REG_SEL_A; req_src2 = REG_SEL_B; req_dst = REG_SEL_C; req_opc = 5'd4;
    @(posedge CLK); @(negedge CLK);
    req_valid = 1'b0;
    @(posedge CLK); @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checkOutput("mid reset ctl", 32'({op_valid, req_ready, rf_sel, rf_load}), 32'({1'b0, 1'b1, REG_SEL_NONE, 1'b0}));
    checkOutput("mid reset op", 32'({op_a == '0, op_dst}), 32'({1'b1, REG_SEL_NONE}));
    wb_valid = 1'b1; wb_sel = REG_SEL_C; wb_data = 19'h00777;
    #1;
    checkOutput("reset wb pass", 32'({rf_load, rf_sel, rf_wdata}), 32'({1'b1, REG_SEL_C, 19'h00777}));
    shadow[REG_SEL_C] = 19'h00777;
    @(posedge CLK); @(negedge CLK);
    driveWb(1'b0, 1'b0, REG_SEL_NONE, '0);
    checkOutput("reset held idle", 32'({op_valid, req_ready}), 32'b01);
    RST_N = 1'b1;
    applyStimulus(REG_SEL_C, REG_SEL_B, REG_SEL_A, 5'd17, 0, 1'b0, -1, REG_SEL_NONE, '0,
                  gA, gB, gD, gO, gL, mA, mB, mL);
    checkOutput("post reset op_a", 32'(gA), 32'h00777);
    checkOutput("post reset op_b", 32'(gB), 32'h00042);
    checkOutput("post reset op_dst/opc", 32'({gD, gO}), 32'({REG_SEL_A, 5'd17}));
    checkOutput("post reset latency", 32'(gL), 32'd4);

    for (int n = 0; n < 40; n++) begin
      rs1  = 2'($urandom_range(0, 3));
      rs2  = 2'($urandom_range(0, 3));
      rd   = 2'($urandom_range(0, 3));
      ropc = OPC_W'($urandom);
      applyStimulus(rs1, rs2, rd, ropc, $urandom_range(0, 2), 1'b1, -1, REG_SEL_NONE, '0,
                    gA, gB, gD, gO, gL, mA, mB, mL);
      checkOutput($sformatf("rnd%0d op_a", n), 32'(gA), 32'(mA));
      checkOutput($sformatf("rnd%0d op_b", n), 32'(gB), 32'(mB));
      checkOutput($sformatf("rnd%0d op_dst/opc", n), 32'({gD, gO}), 32'({rd, ropc}));
      checkOutput($sformatf("rnd%0d latency", n), 32'(gL), 32'(mL));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
